// File: rtl/pkg_dtypes.sv
// Shared backend datatypes: exec unit addressing, icon data and the
// receive-port FIFO entry {src_addr, data}.
package pkg_dtypes;

  localparam int NUM_EXEC_UNITS       = 4;
  localparam int EXEC_UNIT_ADDR_WIDTH = 3;
  localparam int ICON_DATA_WIDTH      = 16;

  typedef logic [NUM_EXEC_UNITS-1:0]       type_icon_receivers_list;
  typedef logic [EXEC_UNIT_ADDR_WIDTH-1:0] type_exec_unit_addr;
  typedef logic [ICON_DATA_WIDTH-1:0]      type_icon_data;

  typedef struct packed {
    type_exec_unit_addr src_addr;
    type_icon_data      data;
  } type_icon_rx_entry;

endpackage

// File: rtl/back_icon_rx_fifo.sv
// Operand FIFO of the icon receive port: storage, wrapping pointers, count, flush.
// Ports: clk, reset_n, flush, push/push_data, pop, head, valid, full.
module back_icon_rx_fifo
  import pkg_dtypes::*;
#(
  parameter int LOG2_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  type_icon_rx_entry push_data,
  input  logic              pop,
  output type_icon_rx_entry head,
  output logic              valid,
  output logic              full
);

  localparam int DEPTH = 2 ** LOG2_FIFO_DEPTH;
  localparam int CW    = LOG2_FIFO_DEPTH + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  type_icon_rx_entry          mem [DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic                       do_push;
  logic                       do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_FULL);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/back_icon_rx_port.sv
// Icon receive port: fixed-priority pick of one requesting channel per cycle,
// same-cycle success bit, operand FIFO toward the exec unit. Perf counters
// exist only with ICON_RX_PERF_CNT_EN defined.
// Ports: clk, reset_n, receiver_lists_i, src_addrs_i, icon_data_i,
// success_lists_o, flush_i, operand_o/valid_o/ready_i, perf_accepts_o,
// perf_conflicts_o.
module back_icon_rx_port
  import pkg_dtypes::*;
#(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int RECEIVER_IDX      = 0,
  parameter int LOG2_FIFO_DEPTH   = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  type_icon_receivers_list [NUM_ICON_CHANNELS-1:0] receiver_lists_i,
  input  type_exec_unit_addr      [NUM_ICON_CHANNELS-1:0] src_addrs_i,
  input  type_icon_data           [NUM_ICON_CHANNELS-1:0] icon_data_i,
  output type_icon_receivers_list [NUM_ICON_CHANNELS-1:0] success_lists_o,
  input  logic                    flush_i,
  output type_icon_rx_entry       operand_o,
  output logic                    operand_valid_o,
  input  logic                    operand_ready_i,
  output logic [31:0]             perf_accepts_o,
  output logic [31:0]             perf_conflicts_o
);

  localparam int NCH  = NUM_ICON_CHANNELS;
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    req;
  logic [CH_W-1:0]   win;
  logic              found;
  logic              full;
  logic              accept;
  logic              pop;
  type_icon_rx_entry push_data;
  logic              unused_bits;

  assign unused_bits = ^receiver_lists_i;

  always_comb begin
    for (int ch = 0; ch < NCH; ch++)
      req[ch] = receiver_lists_i[ch][RECEIVER_IDX];
  end

  // Scan downward so the lowest requesting channel is the last to write.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int ch = NCH - 1; ch >= 0; ch--) begin
      if (req[ch]) begin
        win   = CH_W'(ch);
        found = 1'b1;
      end
    end
  end

  // Gated by reset_n so success drops asynchronously with reset.
  assign accept = found & ~full & ~flush_i & reset_n;
  assign pop    = operand_valid_o & operand_ready_i;

  always_comb begin
    success_lists_o = '0;
    if (accept)
      success_lists_o[win][RECEIVER_IDX] = 1'b1;
  end

  assign push_data = '{src_addr: src_addrs_i[win],
                       data:     icon_data_i[win]};

  back_icon_rx_fifo #(
    .LOG2_FIFO_DEPTH(LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush_i),
    .push     (accept),
    .push_data(push_data),
    .pop      (pop),
    .head     (operand_o),
    .valid    (operand_valid_o),
    .full     (full)
  );

`ifdef ICON_RX_PERF_CNT_EN
  logic [31:0] acc_q;
  logic [31:0] conf_q;
  logic        conflict;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign conflict = |(req & (req - NCH'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      conf_q <= '0;
    end else begin
      if (accept && acc_q != '1)
        acc_q <= acc_q + 32'd1;
      if (conflict && conf_q != '1)
        conf_q <= conf_q + 32'd1;
    end
  end

  assign perf_accepts_o   = acc_q;
  assign perf_conflicts_o = conf_q;
`else
  assign perf_accepts_o   = '0;
  assign perf_conflicts_o = '0;
`endif

endmodule

// File: tb/tb_back_icon_rx_port.sv
// Scoreboard bench for back_icon_rx_port: directed stimulus pushes expected
// operands, a negedge monitor pops and compares on every handshake.
module tb_back_icon_rx_port;
  import pkg_dtypes::*;

  localparam int NCH = 4;
  localparam int IDX = 0;
`ifdef ICON_RX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic flush;
  logic ready;
  type_icon_receivers_list [NCH-1:0] rl;
  type_exec_unit_addr      [NCH-1:0] src;
  type_icon_data           [NCH-1:0] dat;
  type_icon_receivers_list [NCH-1:0] succ;
  type_icon_rx_entry op;
  logic        op_valid;
  logic [31:0] perf_acc;
  logic [31:0] perf_conf;

  int checks = 0;
  int errors = 0;
  type_icon_rx_entry exp_q[$];

  back_icon_rx_port #(
    .NUM_ICON_CHANNELS(NCH),
    .RECEIVER_IDX(IDX),
    .LOG2_FIFO_DEPTH(2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .receiver_lists_i(rl),
    .src_addrs_i     (src),
    .icon_data_i     (dat),
    .success_lists_o (succ),
    .flush_i         (flush),
    .operand_o       (op),
    .operand_valid_o (op_valid),
    .operand_ready_i (ready),
    .perf_accepts_o  (perf_acc),
    .perf_conflicts_o(perf_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic type_icon_rx_entry ent(input int s, input int d);
    ent.src_addr = type_exec_unit_addr'(s);
    ent.data     = type_icon_data'(d);
  endfunction

  task automatic chk_succ(input string n, input int ch);
    logic [NCH*NUM_EXEC_UNITS-1:0] e;
    e = '0;
    if (ch >= 0)
      e[ch*NUM_EXEC_UNITS+IDX] = 1'b1;
    chk(n, 64'(succ), 64'(e));
  endtask

  task automatic idle();
    rl  = '0;
    src = '0;
    dat = '0;
  endtask

  task automatic present(input int ch, input int s, input int d);
    rl[ch][IDX] = 1'b1;
    src[ch]     = type_exec_unit_addr'(s);
    dat[ch]     = type_icon_data'(d);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input string tag);
    idle();
    ready = 1'b1;
    repeat (n) nxt();
    ready = 1'b0;
    @(negedge clk);
    chk(tag, 64'(op_valid), 64'(0));
    nxt();
  endtask

  always @(negedge clk) begin
    if (reset_n && op_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL operand_pop: got %0h expected none", op);
      end else begin
        chk("operand_pop", 64'(op), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int k;
    int cnt_m;
    int cyc;
    bit acc;
    bit pop_m;
    reset_n = 1'b0;
    flush   = 1'b0;
    ready   = 1'b0;
    idle();
    present(1, 1, 'h77);
    #3;
    chk("reset_success", 64'(succ), 64'(0));
    chk("reset_valid", 64'(op_valid), 64'(0));
    chk("reset_perf_acc", 64'(perf_acc), 64'(0));
    idle();
    nxt();
    nxt();
    reset_n = 1'b1;

    // single request on ch2
    present(2, 5, 'hA5);
    exp_q.push_back(ent(5, 'hA5));
    @(negedge clk);
    chk_succ("single_success", 2);
    chk("single_no_bypass", 64'(op_valid), 64'(0));
    nxt();
    idle();
    @(negedge clk);
    chk("single_valid", 64'(op_valid), 64'(1));
    chk("single_operand", 64'(op), 64'(ent(5, 'hA5)));
    chk_succ("single_idle", -1);
    nxt();
    drain(1, "single_drained");

    // conflict ch1 vs ch3
    present(1, 1, 'h11);
    present(3, 3, 'h33);
    exp_q.push_back(ent(1, 'h11));
    @(negedge clk);
    chk_succ("conflict_ch1", 1);
    nxt();
    rl[1] = '0;
    exp_q.push_back(ent(3, 'h33));
    @(negedge clk);
    chk_succ("conflict_ch3", 3);
    nxt();
    idle();
    @(negedge clk);
    chk("conflict_perf", 64'(perf_conf), PERF ? 64'(1) : 64'(0));
    nxt();
    drain(2, "conflict_drained");

    // full: four accepted, fifth held
    for (int i = 0; i < 4; i++) begin
      idle();
      present(0, i + 1, 'h40 + i);
      exp_q.push_back(ent(i + 1, 'h40 + i));
      @(negedge clk);
      chk_succ("full_fill", 0);
      nxt();
    end
    idle();
    present(0, 5, 'h44);
    @(negedge clk);
    chk_succ("full_hold", -1);
    chk("full_valid", 64'(op_valid), 64'(1));
    nxt();
    ready = 1'b1;
    @(negedge clk);
    chk_succ("full_pop_blocks", -1);
    nxt();
    ready = 1'b0;
    exp_q.push_back(ent(5, 'h44));
    @(negedge clk);
    chk_succ("full_after_pop", 0);
    nxt();
    drain(4, "full_drained");

    // wrap: 10 operands with ready toggling, small occupancy model
    k     = 0;
    cnt_m = 0;
    cyc   = 0;
    while ((k < 10 || cnt_m > 0) && cyc < 80) begin
      idle();
      ready = (cyc % 3 != 0);
      acc   = (k < 10) && (cnt_m < 4);
      pop_m = (cnt_m > 0) && ready;
      if (k < 10)
        present(0, k % 8, 'h100 + k);
      if (acc)
        exp_q.push_back(ent(k % 8, 'h100 + k));
      @(negedge clk);
      chk_succ("wrap_success", acc ? 0 : -1);
      chk("wrap_valid", 64'(op_valid), 64'(cnt_m > 0));
      nxt();
      cnt_m = cnt_m + int'(acc) - int'(pop_m);
      k     = k + int'(acc);
      cyc++;
    end
    if (cyc >= 80) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got %0d cycles expected <80", cyc);
    end
    drain(1, "wrap_drained");

    // flush with 3 entries and a pending request
    for (int i = 0; i < 3; i++) begin
      idle();
      present(0, i, 'h60 + i);
      exp_q.push_back(ent(i, 'h60 + i));
      @(negedge clk);
      chk_succ("flush_fill", 0);
      nxt();
    end
    idle();
    present(2, 6, 'h66);
    flush = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    chk_succ("flush_no_success", -1);
    nxt();
    exp_q.delete();
    flush = 1'b0;
    ready = 1'b0;
    exp_q.push_back(ent(6, 'h66));
    @(negedge clk);
    chk("flush_valid", 64'(op_valid), 64'(0));
    chk_succ("flush_then_accept", 2);
    nxt();
    idle();
    @(negedge clk);
    chk("flush_post_valid", 64'(op_valid), 64'(1));
    chk("perf_acc_total", 64'(perf_acc), PERF ? 64'(22) : 64'(0));
    nxt();
    drain(1, "flush_drained");

    // reset in the middle of traffic
    for (int i = 0; i < 2; i++) begin
      idle();
      present(1, 2, 'h80 + i);
      nxt();
    end
    idle();
    present(3, 7, 'h99);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_success", 64'(succ), 64'(0));
    chk("midreset_valid", 64'(op_valid), 64'(0));
    chk("midreset_operand", 64'(op), 64'(0));
    chk("midreset_perf_acc", 64'(perf_acc), 64'(0));
    chk("midreset_perf_conf", 64'(perf_conf), 64'(0));
    exp_q.delete();
    idle();
    nxt();
    nxt();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 64'(op_valid), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
